// File: rtl/btn_pkg.sv
// Shared types and constants for the user-button conditioning path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package btn_pkg;

  // Press classifier states.
  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    LONG,
    RST
  } btn_state_e;

  // Cycle constants for the 48 MHz board clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 480000;    // 10 ms
  localparam int unsigned DEF_LONG_CYCLES     = 24000000;  // 0.5 s
  localparam int unsigned DEF_RESET_CYCLES    = 96000000;  // 2 s
  localparam int unsigned DEF_DCLICK_CYCLES   = 12000000;  // 250 ms

  // Small set that keeps simulations short while preserving the ordering
  // LONG < RESET and a double-click window longer than the debounce time.
  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
  localparam int unsigned SIM_LONG_CYCLES     = 20;
  localparam int unsigned SIM_RESET_CYCLES    = 40;
  localparam int unsigned SIM_DCLICK_CYCLES   = 10;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_conditioner_debounce.sv
// Synchronizes the raw active-low pad and filters out bounces shorter than DEBOUNCE_CYCLES.
// Latency: 2 + DEBOUNCE_CYCLES cycles from pad edge to o_pressed.
// Backpressure: none; free-running filter, output is a level.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_pressed
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_raw_pressed;

  // Two-flop synchronizer; resets to the released (high) pad level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw_pressed = ~r_sync2;

  // Accept a level change only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_raw_pressed == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The debounced level register drives the output directly.
  assign o_pressed = r_level;

endmodule

// File: rtl/btn_conditioner.sv
// Turns the raw usr_btn pad into a debounced level plus short/double/long strobes and a reset request.
// Latency: level 2+DEBOUNCE_CYCLES; short DCLICK_CYCLES after release; double/long 1 cycle after decision.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
  parameter int unsigned DCLICK_CYCLES   = DEF_DCLICK_CYCLES
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic usr_btn,
  output logic btn_pressed,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic reset_req_n
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned GAP_W  = $clog2(DCLICK_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_RST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RESET_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(DCLICK_CYCLES - 1);

  btn_state_e        r_state;
  btn_state_e        w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [GAP_W-1:0]  r_gap;
  logic              r_short;
  logic              r_double;
  logic              r_long;
  logic              r_reset_req_n;
  logic              w_short_nxt;
  logic              w_double_nxt;
  logic              w_long_nxt;
  logic              w_pressed;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk    (clk48),
    .i_rst_n  (rst_n),
    .i_btn_n  (usr_btn),
    .o_pressed(w_pressed)
  );

  // Hold counter: 0 in the first pressed cycle, saturates so long holds never wrap.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!w_pressed) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_MAX) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Gap counter: cycles since the debounced release (release cycle is 0); idle at 0 outside GAP.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if (w_state_nxt == GAP) begin
      r_gap <= r_gap + 1'b1;
    end else begin
      r_gap <= '0;
    end
  end

  // Classifier state register.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode. IDLE reacts to the pressed level, not an edge, so a press
  // that lands on the gap-expiry cycle is still picked up as a fresh PRESS1 one cycle later.
  always_comb begin
    w_state_nxt  = r_state;
    w_short_nxt  = 1'b0;
    w_double_nxt = 1'b0;
    w_long_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pressed) w_state_nxt = PRESS1;
      end
      PRESS1: begin
        if (!w_pressed) begin
          w_state_nxt = GAP;
        end else if (r_hold == HOLD_LONG) begin
          w_long_nxt  = 1'b1;
          w_state_nxt = LONG;
        end
      end
      GAP: begin
        // Expiry wins over a coincident press.
        if (r_gap == GAP_LAST) begin
          w_short_nxt = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_pressed) begin
          w_state_nxt = PRESS2;
        end
      end
      PRESS2: begin
        if (!w_pressed) begin
          w_double_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else if (r_hold == HOLD_LONG) begin
          // The first short press is dropped; this becomes a plain long press.
          w_long_nxt  = 1'b1;
          w_state_nxt = LONG;
        end
      end
      LONG: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE;
        end else if (r_hold == HOLD_RST) begin
          w_state_nxt = RST;
        end
      end
      RST: begin
        if (!w_pressed) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered strobes and reset request so downstream logic sees glitch-free outputs.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_short       <= 1'b0;
      r_double      <= 1'b0;
      r_long        <= 1'b0;
      r_reset_req_n <= 1'b1;
    end else begin
      r_short       <= w_short_nxt;
      r_double      <= w_double_nxt;
      r_long        <= w_long_nxt;
      r_reset_req_n <= (w_state_nxt != RST);
    end
  end

  assign btn_pressed  = w_pressed;
  assign short_pulse  = r_short;
  assign double_pulse = r_double;
  assign long_pulse   = r_long;
  assign reset_req_n  = r_reset_req_n;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner using a cycle-stamped event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_btn_conditioner;

  localparam int DB     = 4;
  localparam int LONG_C = 20;
  localparam int RST_C  = 40;
  localparam int DCLICK = 10;
  localparam int LAT    = DB + 2;   // pad edge to btn_pressed

  logic clk48   = 1'b0;
  logic rst_n   = 1'b1;
  logic usr_btn = 1'b1;
  logic btn_pressed;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic reset_req_n;

  typedef enum int {
    EV_BTN_RISE, EV_BTN_FALL, EV_SHORT, EV_DOUBLE, EV_LONG, EV_RST_ASSERT, EV_RST_DEASSERT
  } ev_e;

  typedef struct {
    ev_e ev;
    int  cyc;
  } exp_t;

  exp_t exp_q[$];
  ev_e  obs_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hit;
  bit   mon_en  = 1'b0;
  logic prev_btn  = 1'b0;
  logic prev_rstn = 1'b1;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG_C),
    .RESET_CYCLES   (RST_C),
    .DCLICK_CYCLES  (DCLICK)
  ) dut (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .usr_btn     (usr_btn),
    .btn_pressed (btn_pressed),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .reset_req_n (reset_req_n)
  );

  always #5 clk48 = ~clk48;

  always @(posedge clk48) cyc = cyc + 1;

  // Monitor: every observed output event must match a pending expectation stamped with this cycle.
  always @(negedge clk48) begin
    if (mon_en) begin
      obs_q = {};
      if (btn_pressed !== prev_btn) obs_q.push_back(btn_pressed ? EV_BTN_RISE : EV_BTN_FALL);
      if (reset_req_n !== prev_rstn) obs_q.push_back(reset_req_n ? EV_RST_DEASSERT : EV_RST_ASSERT);
      if (short_pulse === 1'b1) obs_q.push_back(EV_SHORT);
      if (double_pulse === 1'b1) obs_q.push_back(EV_DOUBLE);
      if (long_pulse === 1'b1) obs_q.push_back(EV_LONG);
      if ((short_pulse | double_pulse | long_pulse) === 1'b1) begin
        n_tests++;
        if ($countones({short_pulse, double_pulse, long_pulse}) > 1) begin
          n_fail++;
          $display("FAIL pulse_exclusive: cycle %0d got s/d/l=%b%b%b, required at most one high",
                   cyc, short_pulse, double_pulse, long_pulse);
        end
      end
      foreach (obs_q[k]) begin
        hit = -1;
        foreach (exp_q[j]) begin
          if (hit < 0 && exp_q[j].ev == obs_q[k] && exp_q[j].cyc == cyc) hit = j;
        end
        n_tests++;
        if (hit < 0) begin
          n_fail++;
          $display("FAIL event_match: got %s at cycle %0d, required no such event then (%0d pending)",
                   obs_q[k].name(), cyc, exp_q.size());
        end else begin
          exp_q.delete(hit);
        end
      end
    end
    prev_btn  = btn_pressed;
    prev_rstn = reset_req_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic expect_ev(input ev_e ev, input int c);
    exp_t e;
    e.ev  = ev;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    tick(2);
    n_tests++; if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_btn: got %b, required 0", btn_pressed); end
    n_tests++; if (short_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b, required 0", short_pulse); end
    n_tests++; if (double_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_double: got %b, required 0", double_pulse); end
    n_tests++; if (long_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_long: got %b, required 0", long_pulse); end
    n_tests++; if (reset_req_n !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b, required 1", reset_req_n); end
    rst_n = 1'b1;
    tick(3);
    mon_en = 1'b1;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 3; i++) begin
      usr_btn = 1'b0;
      tick(2);
      usr_btn = 1'b1;
      tick(2);
    end
    tick(30);
    n_tests++;
    if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL bounce_level: got %b, required 0", btn_pressed); end
  endtask

  task automatic test_short();
    int c0;
    c0 = cyc;
    expect_ev(EV_BTN_RISE, c0 + LAT);
    expect_ev(EV_BTN_FALL, c0 + 8 + LAT);
    expect_ev(EV_SHORT,    c0 + 8 + LAT + DCLICK);
    usr_btn = 1'b0;
    tick(8);
    usr_btn = 1'b1;
    tick(30);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL short_drained: %0d events missing, first %s due cycle %0d", exp_q.size(), exp_q[0].ev.name(), exp_q[0].cyc);
    end
    exp_q = {};
  endtask

  task automatic test_double();
    int c0;
    c0 = cyc;
    expect_ev(EV_BTN_RISE, c0 + LAT);
    expect_ev(EV_BTN_FALL, c0 + 8 + LAT);
    expect_ev(EV_BTN_RISE, c0 + 14 + LAT);
    expect_ev(EV_BTN_FALL, c0 + 22 + LAT);
    expect_ev(EV_DOUBLE,   c0 + 22 + LAT + 1);
    usr_btn = 1'b0;
    tick(8);
    usr_btn = 1'b1;
    tick(6);
    usr_btn = 1'b0;
    tick(8);
    usr_btn = 1'b1;
    tick(30);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL double_drained: %0d events missing, first %s due cycle %0d", exp_q.size(), exp_q[0].ev.name(), exp_q[0].cyc);
    end
    exp_q = {};
  endtask

  task automatic test_long_reset();
    int c0;
    c0 = cyc;
    expect_ev(EV_BTN_RISE,     c0 + LAT);
    expect_ev(EV_LONG,         c0 + LAT + LONG_C);
    expect_ev(EV_RST_ASSERT,   c0 + LAT + RST_C);
    expect_ev(EV_BTN_FALL,     c0 + 60 + LAT);
    expect_ev(EV_RST_DEASSERT, c0 + 60 + LAT + 1);
    usr_btn = 1'b0;
    tick(60);
    usr_btn = 1'b1;
    tick(30);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_drained: %0d events missing, first %s due cycle %0d", exp_q.size(), exp_q[0].ev.name(), exp_q[0].cyc);
    end
    exp_q = {};
  endtask

  // Second press debounced exactly on the last gap cycle: expiry wins, then a new press is classified.
  task automatic test_gap_collision();
    int c0;
    c0 = cyc;
    expect_ev(EV_BTN_RISE, c0 + LAT);
    expect_ev(EV_BTN_FALL, c0 + 8 + LAT);
    expect_ev(EV_BTN_RISE, c0 + 8 + LAT + DCLICK - 1);
    expect_ev(EV_SHORT,    c0 + 8 + LAT + DCLICK);
    expect_ev(EV_BTN_FALL, c0 + 8 + LAT + DCLICK - 1 + 8);
    expect_ev(EV_SHORT,    c0 + 8 + LAT + DCLICK - 1 + 8 + DCLICK);
    usr_btn = 1'b0;
    tick(8);
    usr_btn = 1'b1;
    tick(DCLICK - 1);
    usr_btn = 1'b0;
    tick(8);
    usr_btn = 1'b1;
    tick(30);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL collision_drained: %0d events missing, first %s due cycle %0d", exp_q.size(), exp_q[0].ev.name(), exp_q[0].cyc);
    end
    exp_q = {};
  endtask

  task automatic test_reset_mid_hold();
    int c0;
    int c1;
    c0 = cyc;
    expect_ev(EV_BTN_RISE,   c0 + LAT);
    expect_ev(EV_LONG,       c0 + LAT + LONG_C);
    expect_ev(EV_RST_ASSERT, c0 + LAT + RST_C);
    usr_btn = 1'b0;
    tick(50);
    expect_ev(EV_RST_DEASSERT, cyc);
    expect_ev(EV_BTN_FALL,     cyc);
    rst_n = 1'b0;
    #1;
    n_tests++; if (reset_req_n !== 1'b1) begin n_fail++; $display("FAIL midrst_req: got %b, required 1", reset_req_n); end
    n_tests++; if (btn_pressed !== 1'b0) begin n_fail++; $display("FAIL midrst_btn: got %b, required 0", btn_pressed); end
    tick(3);
    rst_n = 1'b1;
    c1 = cyc;
    expect_ev(EV_BTN_RISE, c1 + LAT);
    expect_ev(EV_BTN_FALL, c1 + 8 + LAT);
    expect_ev(EV_SHORT,    c1 + 8 + LAT + DCLICK);
    tick(8);
    usr_btn = 1'b1;
    tick(30);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_drained: %0d events missing, first %s due cycle %0d", exp_q.size(), exp_q[0].ev.name(), exp_q[0].cyc);
    end
    exp_q = {};
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short();
    test_double();
    test_long_reset();
    test_gap_collision();
    test_reset_mid_hold();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw active-low usr_btn pad into clean, single-cycle user events for the top-level control logic.
- Signal chain: 2-flop synchronizer, then debounce filter, then press classifier FSM.
- Classifier outputs: short, double, long, and hold-reset events.
- Sits directly upstream of the LED/reset logic; replaces ad-hoc raw-button counters in top.

Parameters:
- DEBOUNCE_CYCLES, 480000: consecutive stable synchronized samples required to accept a level change (10 ms at 48 MHz).
- LONG_CYCLES, 24000000: debounced hold duration that qualifies a long press (0.5 s).
- RESET_CYCLES, 96000000: debounced hold duration that requests board reset (2 s). Must exceed LONG_CYCLES.
- DCLICK_CYCLES, 12000000: window after a short release in which a second press makes a double press (250 ms).

Ports:
- clk48  input  1  system clock, 48 MHz
- rst_n  input  1  asynchronous active-low reset
- usr_btn  input  1  raw button pad, active-low (0 = pressed), asynchronous to clk48
- btn_pressed  output  1  debounced level, 1 = pressed
- short_pulse  output  1  one-cycle strobe: single short press completed
- double_pulse  output  1  one-cycle strobe: two short presses within window
- long_pulse  output  1  one-cycle strobe: hold reached LONG_CYCLES
- reset_req_n  output  1  active-low board-reset request, level

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchronizer flops = 1 (released); debounced level = released.
  - All counters = 0; FSM = IDLE.
  - btn_pressed = 0; all pulses = 0; reset_req_n = 1.
- Synchronizer: two flops on usr_btn. Its output is inverted to give an active-high raw_pressed.
- Debounce:
  - Counter increments while raw_pressed differs from the debounced level; it clears to 0 whenever they match.
  - When the count reaches DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level toggles and the counter clears.
  - btn_pressed is registered and follows the debounced level.
  - Latency from pad edge to btn_pressed = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are never seen downstream.
- Hold counter:
  - Width = clog2(RESET_CYCLES+1).
  - Counts cycles while btn_pressed = 1 and saturates at RESET_CYCLES (no wrap).
  - Clears in the cycle btn_pressed goes 0.
- FSM states and transitions:
  - IDLE: on btn_pressed rise, go to PRESS1 with the hold counter starting at 0.
  - PRESS1:
    - Hold counter == LONG_CYCLES-1 while still pressed: long_pulse = 1 for one cycle, go to LONG.
    - Release before that: go to GAP with the gap counter cleared.
  - LONG:
    - Hold counter == RESET_CYCLES-1: go to RST.
    - Release: go to IDLE (no short or double event).
  - RST:
    - reset_req_n = 0 while in this state.
    - On release, reset_req_n returns to 1 on the next cycle; go to IDLE.
  - GAP:
    - Gap counter increments each cycle.
    - Press before the counter reaches DCLICK_CYCLES-1: go to PRESS2.
    - Counter reaches DCLICK_CYCLES-1: short_pulse = 1 for one cycle, go to IDLE.
  - PRESS2:
    - Release before LONG_CYCLES: double_pulse = 1 for one cycle in the release cycle, go to IDLE.
    - Hold reaches LONG_CYCLES-1: long_pulse fires, go to LONG. The first press is discarded; no short_pulse.
- Latency: short_pulse fires DCLICK_CYCLES cycles after the debounced release. This deferral is intended and documented.
- Mutual exclusion: at most one pulse output is high in any cycle. Pulses are registered outputs.
- Simultaneous events: a press arriving in the same cycle the GAP counter expires is treated as expiry. short_pulse fires, the FSM goes to IDLE, and the press is picked up next cycle as a fresh PRESS1.
- Mid-operation reset: the asynchronous clear takes effect immediately. reset_req_n deasserts to 1 even if the FSM was in RST.
- Button still held after reset release: debounce restarts from the released state. btn_pressed rises DEBOUNCE_CYCLES+2 later, then a normal PRESS1 begins.
- reset_req_n is registered and glitch-free. It feeds the existing board rst_n output in top.

Decomposition:
- Package btn_pkg holds:
  - FSM state enum: IDLE, PRESS1, GAP, PRESS2, LONG, RST.
  - Default cycle constants for 48 MHz.
  - A small-parameter set for simulation.
- One natural sub-module: btn_debounce, containing the synchronizer, debounce counter and btn_pressed register.
- The FSM, hold counter and gap counter stay in btn_conditioner.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, RESET_CYCLES=40, DCLICK_CYCLES=10.
- Bounce: usr_btn toggles every 2 cycles for 12 cycles, then stays 1 -> btn_pressed stays 0, no pulses.
- Short press: usr_btn low 8 cycles, then high -> btn_pressed high for 8 cycles; exactly one short_pulse, 10 cycles after debounced release.
- Double press: two 8-cycle lows separated by 6 high cycles -> one double_pulse at the second debounced release; no short_pulse.
- Long then reset: usr_btn low 60 cycles -> long_pulse at hold count 19; reset_req_n low from hold count 39 until 1 cycle after debounced release; no short or double.
- Reset mid-hold: assert rst_n low while in RST -> reset_req_n = 1 and btn_pressed = 0 immediately. Release rst_n with button held -> btn_pressed rises 6 cycles later; no pulse until a new classification completes.
- Gap-expiry collision: second press debounced exactly at gap count 9 -> short_pulse, then the new press is classified independently (press of 8 cycles yields a second short_pulse).
